// File: rtl/ex_pkg.sv
// Shared encodings for the EX-stage M-extension unit: funct3 op codes,
// FSM states and the default datapath width.
package ex_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the iterative multiplier/divider.
// The accumulator is {i_hi, i_lo}. The shifted-in quotient bit lands in o_lo[0].
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_q;

  always_comb begin
    // multiply: conditional add of the multiplicand, then shift the pair right
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    // divide: shift partial remainder left, trial-subtract the divisor
    w_shift = {i_hi, i_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, i_b};
    w_q     = (w_shift >= {1'b0, i_b});
    if (i_div) begin
      o_hi = w_q ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_q};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage with pipeline stall control.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplies; division stays iterative.
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [RD_W-1:0] rd_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [RD_W-1:0] rd_o
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  state_e          r_state, w_next_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_b;
  logic            r_neg;
  funct3_e         r_op;
  logic [RD_W-1:0] r_rd_tag;
  logic [XLEN-1:0] r_result;
  logic [RD_W-1:0] r_rd;

  funct3_e         w_op;
  logic            w_accept, w_is_div, w_sa, w_sb, w_neg;
  logic            w_div_zero, w_ovf, w_fast, w_short, w_last;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_special, w_fast_res;
  logic [XLEN-1:0] w_step_hi, w_step_lo;

  function automatic logic [XLEN-1:0] f_fixup(input funct3_e op, input logic neg,
                                              input logic [XLEN-1:0] hi,
                                              input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] prod;
    prod = neg ? -{hi, lo} : {hi, lo};
    case (op)
      OP_MUL:                       return prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              return neg ? -lo : lo;
      default:                      return neg ? -hi : hi;
    endcase
  endfunction

  assign w_op     = funct3_e'(funct3_i);
  assign w_accept = valid_i && (r_state == S_IDLE) && !flush_i;
  assign w_is_div = funct3_i[2];
  assign w_sa     = op_a_i[XLEN-1] && (w_op == OP_MULH || w_op == OP_MULHSU ||
                                       w_op == OP_DIV  || w_op == OP_REM);
  assign w_sb     = op_b_i[XLEN-1] && (w_op == OP_MULH || w_op == OP_DIV ||
                                       w_op == OP_REM);
  // remainder takes the dividend's sign; everything else the XOR of both
  assign w_neg    = (w_op == OP_REM) ? w_sa : (w_sa ^ w_sb);
  assign w_mag_a  = w_sa ? -op_a_i : op_a_i;
  assign w_mag_b  = w_sb ? -op_b_i : op_b_i;

  assign w_div_zero = w_is_div && (op_b_i == '0);
  assign w_ovf      = (w_op == OP_DIV || w_op == OP_REM) &&
                      (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
  assign w_fast      = !w_is_div;
  assign w_fast_res  = f_fixup(w_op, w_neg, w_fast_prod[2*XLEN-1:XLEN],
                               w_fast_prod[XLEN-1:0]);
`else
  assign w_fast      = 1'b0;
  assign w_fast_res  = '0;
`endif

  assign w_short = w_div_zero || w_ovf || w_fast;

  always_comb begin
    w_special = w_fast_res;
    if (w_div_zero)
      w_special = (w_op == OP_DIV || w_op == OP_DIVU) ? '1 : op_a_i;
    else if (w_ovf)
      w_special = (w_op == OP_DIV) ? op_a_i : '0;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_div (r_op[2]),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .i_b   (r_b),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );

  assign w_last = (r_cnt == CW'(XLEN - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_short ? S_DONE : S_CALC;
      S_CALC:  if (w_last)   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (flush_i) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_op     <= OP_MUL;
      r_rd_tag <= '0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (r_state == S_IDLE && w_accept) begin
      // mul: lo = multiplier, b = multiplicand; div: lo = dividend, b = divisor
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= w_is_div ? w_mag_a : w_mag_b;
      r_b      <= w_is_div ? w_mag_b : w_mag_a;
      r_neg    <= w_neg;
      r_op     <= w_op;
      r_rd_tag <= rd_i;
      if (w_short) begin
        r_result <= w_special;
        r_rd     <= rd_i;
      end
    end else if (r_state == S_CALC && !flush_i) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= f_fixup(r_op, r_neg, w_step_hi, w_step_lo);
        r_rd     <= r_rd_tag;
      end
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign stall_o  = (r_state == S_CALC) || ((r_state == S_IDLE) && valid_i && !flush_i);
  assign done_o   = (r_state == S_DONE);
  assign result_o = r_result;
  assign rd_o     = r_rd;

endmodule
